// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-and-add sequencer for an unsigned 32x32->64 multiply
// that borrows the shared combinational ALU, one ADDcc per cycle.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, a_in, b_in    request and operands, accepted only in IDLE
//   busy, done           busy while not IDLE; done pulses one cycle with result
//   prod_hi, prod_lo     64-bit product, held until the next accepted start
//   alu_op/a/b/ci        operands and opcode issued to the shared ALU
//   alu_y, alu_c         same-cycle ALU result and carry-out
//   cc_we, cc_n, cc_z    N/Z condition-code update, strobed with done
module mul_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_ci,
  input  logic [31:0] alu_y,
  input  logic        alu_c,
  output logic        cc_we,
  output logic        cc_n,
  output logic        cc_z
);

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned OP_W    = 6;
  localparam logic [OP_W-1:0]  OP_PASS_A = 6'b100000;
  localparam logic [OP_W-1:0]  OP_ADDCC  = 6'b010000;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m, m_nxt;
  logic [WIDTH-1:0]   hi, hi_nxt;
  logic [WIDTH-1:0]   lo, lo_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, datapath update and state-decoded outputs
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    hi_nxt    = hi;
    lo_nxt    = lo;
    cnt_nxt   = cnt;
    busy      = 1'b1;
    done      = 1'b0;
    cc_we     = 1'b0;
    alu_op    = OP_PASS_A;
    alu_a     = '0;
    alu_b     = '0;
    alu_ci    = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          m_nxt     = a_in;
          lo_nxt    = b_in;
          hi_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = ITER;
        end
      end
      ITER: begin
        alu_op  = OP_ADDCC;
        alu_a   = hi;
        alu_b   = lo[0] ? m : '0;
        // Shift the 65-bit {carry, sum, lo} right by one; lo drains the multiplier.
        hi_nxt  = {alu_c, alu_y[WIDTH-1:1]};
        lo_nxt  = {alu_y[0], lo[WIDTH-1:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        cc_we     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign prod_hi = hi;
  assign prod_lo = lo;
  assign cc_n    = hi[WIDTH-1];
  assign cc_z    = ~|{hi, lo};

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: models the external ALU, runs a table of directed
// multiplies, then hand-written busy-start, mid-op reset and back-to-back cases.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] prod_hi, prod_lo;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_ci;
  logic [31:0] alu_y;
  logic        alu_c;
  logic        cc_we, cc_n, cc_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_c(alu_c),
    .cc_we(cc_we), .cc_n(cc_n), .cc_z(cc_z)
  );

  // Shared ALU: ADDcc produces sum and carry, everything else passes A.
  always_comb begin
    alu_y = alu_a;
    alu_c = 1'b0;
    if (alu_op == 6'b010000) begin
      {alu_c, alu_y} = 33'(alu_a) + 33'(alu_b) + 33'(alu_ci);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        n;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  // Issue one operation and check latency, ALU issue and final results.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic en, input logic ez, input string tag);
    int  cyc;
    bit  alu_ok;
    bit  bzero;
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    chk({tag, " busy_after_accept"}, 64'(busy), 64'(1));
    cyc = 0; alu_ok = 1'b1; bzero = 1'b1;
    while (!done && cyc < 40) begin
      if (alu_op !== 6'b010000 || alu_ci !== 1'b0) alu_ok = 1'b0;
      if (alu_b !== 32'd0) bzero = 1'b0;
      if (!busy) alu_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(32));
    chk({tag, " iter_alu_issue"}, 64'(alu_ok), 64'(1));
    if (a == 32'd0) chk({tag, " alu_b_zero"}, 64'(bzero), 64'(1));
    chk({tag, " product"}, {prod_hi, prod_lo}, {ehi, elo});
    chk({tag, " cc"}, 64'({cc_we, busy, cc_n, cc_z}), 64'({1'b1, 1'b1, en, ez}));
    chk({tag, " done_alu_idle"}, {alu_op, alu_a, alu_b[25:0]}, {6'b100000, 32'd0, 26'd0});
    @(posedge clk); #1;
    chk({tag, " after_done"}, 64'({done, cc_we, busy}), 64'(0));
    chk({tag, " product_held"}, {prod_hi, prod_lo}, {ehi, elo});
  endtask

  initial begin
    int cyc;
    int dones;
    int last_done;
    int gaps;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;

    vecs.push_back('{32'd8,        32'd7,        32'h00000000, 32'h00000038, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'd1,        32'd1,        32'h00000000, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b0});
    vecs.push_back('{32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'hC0000000, 32'd4,        32'h00000003, 32'h00000000, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, cc_we, alu_ci, prod_hi, prod_lo[27:0]}, 64'd0);
    chk("reset_alu", {alu_op, alu_a, alu_b[25:0]}, {6'b100000, 58'd0});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", 64'({busy, done}), 64'(0));

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n, vecs[i].z,
             $sformatf("vec%0d", i));
    end

    // Start pulsed 5 cycles into an operation must be ignored.
    start = 1'b1; a_in = 32'd8; b_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; a_in = 32'd3; b_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 5; dones = 0;
    while (cyc < 80) begin
      if (done) dones++;
      if (done) chk("busy_start_product", {prod_hi, prod_lo}, 64'd56);
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_start_done_count", 64'(dones), 64'(1));
    chk("busy_start_idle", 64'(busy), 64'(0));

    // Reset at iteration 10 aborts with no done and a cleared product.
    start = 1'b1; a_in = 32'd100; b_in = 32'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_state", {busy, done, cc_we, prod_hi, prod_lo[28:0]}, 64'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || cc_we || busy) dones++;
    end
    chk("midreset_no_done", 64'(dones), 64'(0));
    run_op(32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, "after_reset");

    // Start held high: one IDLE cycle between operations.
    start = 1'b1; a_in = 32'd2; b_in = 32'd3;
    cyc = 0; dones = 0; last_done = -1; gaps = 0;
    while (dones < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        chk("b2b_product", {prod_hi, prod_lo}, 64'd6);
        if (last_done >= 0) chk("b2b_period", 64'(cyc - last_done), 64'(34));
        last_done = cyc;
        dones++;
      end
    end
    chk("b2b_done_count", 64'(dones), 64'(3));
    chk("b2b_first_done", 64'(gaps + (dones > 0 ? 1 : 0)), 64'(1));
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_stopped", 64'({busy, done}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle sequencer for the shared 32-bit ALU: computes an unsigned 32×32→64 product by shift-and-add, issuing one ADDcc per cycle to the combinational ALU and shifting the carry/sum into internal product registers. It sits between the datapath control unit, which uses a start/done handshake, and the ALU operand/op ports. At completion it updates the N and Z condition codes.

## Interface
- WIDTH, 32, operand width; fixed to 32 to match the ALU.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  32  multiplicand, sampled with start
- b_in  in  32  multiplier, sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, product valid
- prod_hi  out  32  product bits [63:32]
- prod_lo  out  32  product bits [31:0]
- alu_op  out  6  ALU opcode
- alu_a  out  32  ALU A operand
- alu_b  out  32  ALU B operand
- alu_ci  out  1  ALU carry-in, always 0
- alu_y  in  32  ALU result
- alu_c  in  1  ALU carry-out; valid for ADDcc
- cc_we  out  1  condition-code write strobe, pulsed with done
- cc_n  out  1  N flag to write, prod_hi[31]
- cc_z  out  1  Z flag to write, 1 iff 64-bit product == 0

## Operation
- Registers:
  - M, the 32-bit multiplicand.
  - hi and lo, each 32 bits; prod_hi = hi and prod_lo = lo.
  - cnt, 5 bits.
- States: IDLE, ITER, DONE.
- IDLE:
  - alu_op = 6'b100000 (pass A), alu_a = 0, alu_b = 0.
  - If start = 1: M ← a_in, lo ← b_in, hi ← 0, cnt ← 0, next state ITER.
- ITER:
  - alu_op = 6'b010000 (ADDcc), alu_a = hi, alu_b = lo[0] ? M : 0, alu_ci = 0.
  - Each edge: hi ← {alu_c, alu_y[31:1]}, lo ← {alu_y[0], lo[31:1]}, cnt ← cnt + 1.
  - When cnt = 31 at the edge, next state is DONE. There are exactly 32 iterations.
- DONE:
  - done = 1 and cc_we = 1.
  - cc_n = hi[31] and cc_z = ~|{hi,lo}.
  - ALU outputs are as in IDLE.
  - Next state is IDLE unconditionally.
- Product arithmetic:
  - Unsigned, modulo 2^64; it never overflows.
  - No signed mode. The V and C flags are not written.
- prod_hi/prod_lo hold the final product after DONE until the next accepted start.
- start is ignored in ITER and DONE; there is no queuing.
- a_in and b_in are don't-care except at the accepting edge.

## Timing
- Reset values: state IDLE, hi = lo = 0, M = 0, cnt = 0, busy = 0, done = 0, cc_we = 0, alu_op = 6'b100000, alu_a = alu_b = 0, alu_ci = 0.
- Reset mid-operation: aborts on the next edge with no done pulse and no cc_we, and clears the product.
- Latency:
  - start is sampled at edge t0.
  - busy is high from t0 through the cycle after t32.
  - done is high for exactly the one cycle after edge t32, i.e. 33 cycles after acceptance.
- Throughput: with start held high, operations run back-to-back with one IDLE cycle between them, i.e. a 34-cycle period.
- All outputs are registered state or purely decoded from state/registers.
- alu_y and alu_c are combinational within the same cycle; there is no ALU pipeline stage.

## Test plan
- Basic multiply: a_in = 8, b_in = 7, start pulse → done 33 cycles later, prod_hi = 0, prod_lo = 56, cc_n = 0, cc_z = 0, cc_we = 1 for one cycle.
- Maximum operands: a_in = b_in = 32'hFFFFFFFF → prod_hi = 32'hFFFFFFFE, prod_lo = 32'h00000001, cc_n = 1. This exercises alu_c on every iteration.
- Zero operand: a_in = 0, b_in = 32'h12345678 → product 0, cc_z = 1, cc_n = 0. Every ALU issue in ITER has alu_b = 0.
- Start while busy: start is pulsed again 5 cycles after acceptance with different operands → ignored. Only the first product is produced, and done pulses once.
- Reset mid-operation: reset asserted for 1 cycle at iteration 10 → next cycle busy = 0, prod_hi = prod_lo = 0. No done or cc_we occurs, and a subsequent start (3 × 5) yields 15.
- Back-to-back: start held high with a_in = 2, b_in = 3 → done pulses every 34 cycles, prod_lo = 6 each time.
